// File: rtl/seven_segment_control.sv
// Purpose: eight-digit hex 7-segment driver; per-digit enable blanks unused digits.
// Latency: one clock from inputs to HEX outputs; async reset blanks immediately.
// Backpressure: none; every digit is reloaded on every clock edge.
module seven_segment_control #(
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] in7,
  input  logic [3:0] in6,
  input  logic [3:0] in5,
  input  logic [3:0] in4,
  input  logic [3:0] in3,
  input  logic [3:0] in2,
  input  logic [3:0] in1,
  input  logic [3:0] in0,
  input  logic [7:0] turn_on,
  output logic [6:0] HEX7,
  output logic [6:0] HEX6,
  output logic [6:0] HEX5,
  output logic [6:0] HEX4,
  output logic [6:0] HEX3,
  output logic [6:0] HEX2,
  output logic [6:0] HEX1,
  output logic [6:0] HEX0
);

  // All segments dark in the selected polarity.
  localparam logic [6:0] BLANK = ACTIVE_LOW ? 7'h7F : 7'h00;
  // XOR mask turning the active-low table into the configured polarity.
  localparam logic [6:0] POL_MASK = ACTIVE_LOW ? 7'h00 : 7'h7F;

  // Shared hex decoder, bit order {g,f,e,d,c,b,a}. The table is written
  // active-low; unknown nibbles fall to blank rather than a random glyph.
  function automatic logic [6:0] decode(input logic [3:0] nib);
    logic [6:0] seg_n;
    seg_n = 7'h7F;
    case (nib)
      4'h0: seg_n = 7'h40;
      4'h1: seg_n = 7'h79;
      4'h2: seg_n = 7'h24;
      4'h3: seg_n = 7'h30;
      4'h4: seg_n = 7'h19;
      4'h5: seg_n = 7'h12;
      4'h6: seg_n = 7'h02;
      4'h7: seg_n = 7'h78;
      4'h8: seg_n = 7'h00;
      4'h9: seg_n = 7'h10;
      4'hA: seg_n = 7'h08;
      4'hB: seg_n = 7'h03;
      4'hC: seg_n = 7'h46;
      4'hD: seg_n = 7'h21;
      4'hE: seg_n = 7'h06;
      4'hF: seg_n = 7'h0E;
      default: seg_n = 7'h7F;
    endcase
    return seg_n ^ POL_MASK;
  endfunction

  logic [3:0] nib   [8];
  logic [6:0] hex_d [8];
  logic [6:0] hex_q [8];

  // Gather the digit nibbles into an array indexed by digit position.
  always_comb begin
    nib[7] = in7;
    nib[6] = in6;
    nib[5] = in5;
    nib[4] = in4;
    nib[3] = in3;
    nib[2] = in2;
    nib[1] = in1;
    nib[0] = in0;
  end

  // Next pattern per digit: decoded nibble when enabled, otherwise blank.
  // The enable selects blank even if the nibble itself is unknown.
  always_comb begin
    for (int i = 0; i < 8; i++) begin
      hex_d[i] = BLANK;
      if (turn_on[i]) begin
        hex_d[i] = decode(nib[i]);
      end
    end
  end

  // Output registers; reset blanks all digits without waiting for a clock.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 8; i++) begin
        hex_q[i] <= BLANK;
      end
    end else begin
      for (int i = 0; i < 8; i++) begin
        hex_q[i] <= hex_d[i];
      end
    end
  end

  assign HEX7 = hex_q[7];
  assign HEX6 = hex_q[6];
  assign HEX5 = hex_q[5];
  assign HEX4 = hex_q[4];
  assign HEX3 = hex_q[3];
  assign HEX2 = hex_q[2];
  assign HEX1 = hex_q[1];
  assign HEX0 = hex_q[0];

endmodule

// File: tb/tb_seven_segment_control.sv
// Bench for seven_segment_control: directed steps with a scoreboard queue.
// Expected patterns come from a local copy of the segment table.
module tb_seven_segment_control;

  logic       clock;
  logic       reset;
  logic [3:0] in_v [8];
  logic [7:0] turn_on;
  logic [6:0] hex_o [8];
  logic [6:0] h7, h6, h5, h4, h3, h2, h1, h0;

  int checks = 0;
  int errors = 0;

  logic [55:0] sb [$];

  logic [6:0] tbl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                           7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  seven_segment_control #(.ACTIVE_LOW(1'b1)) dut (
    .clock  (clock),
    .reset  (reset),
    .in7    (in_v[7]),
    .in6    (in_v[6]),
    .in5    (in_v[5]),
    .in4    (in_v[4]),
    .in3    (in_v[3]),
    .in2    (in_v[2]),
    .in1    (in_v[1]),
    .in0    (in_v[0]),
    .turn_on(turn_on),
    .HEX7   (h7),
    .HEX6   (h6),
    .HEX5   (h5),
    .HEX4   (h4),
    .HEX3   (h3),
    .HEX2   (h2),
    .HEX1   (h1),
    .HEX0   (h0)
  );

  always_comb begin
    hex_o[7] = h7;
    hex_o[6] = h6;
    hex_o[5] = h5;
    hex_o[4] = h4;
    hex_o[3] = h3;
    hex_o[2] = h2;
    hex_o[1] = h1;
    hex_o[0] = h0;
  end

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Compare all eight digits against a packed expectation (digit i at [7i+6:7i]).
  task automatic check_vec(input string tag, input logic [55:0] e);
    for (int i = 0; i < 8; i++) begin
      checks++;
      assert (hex_o[i] === e[i*7 +: 7]) else begin
        errors++;
        $error("FAIL %s HEX%0d: observed %h expected %h", tag, i, hex_o[i], e[i*7 +: 7]);
      end
    end
  endtask

  // Single-digit comparison.
  task automatic check_one(input string tag, input int idx, input logic [6:0] e);
    checks++;
    assert (hex_o[idx] === e) else begin
      errors++;
      $error("FAIL %s HEX%0d: observed %h expected %h", tag, idx, hex_o[idx], e);
    end
  endtask

  // Drive inputs (nibs packed, in7 in the top nibble) and push the expected pattern.
  task automatic drive(input logic [31:0] nibs, input logic [7:0] ton);
    logic [55:0] e;
    logic [3:0]  n;
    e = '0;
    turn_on = ton;
    for (int i = 0; i < 8; i++) begin
      n = nibs[i*4 +: 4];
      in_v[i] = n;
      e[i*7 +: 7] = ton[i] ? tbl[n] : 7'h7F;
    end
    sb.push_back(e);
  endtask

  // One clock edge, then pop the oldest expectation and compare.
  task automatic step(input string tag);
    logic [55:0] e;
    @(posedge clock);
    #1;
    if (sb.size() == 0) begin
      errors++;
      $error("FAIL %s: scoreboard empty, observed HEX0 %h expected a queued pattern", tag, hex_o[0]);
    end else begin
      e = sb.pop_front();
      check_vec(tag, e);
    end
  endtask

  logic [55:0] all_blank;

  initial begin
    all_blank = {8{7'h7F}};

    // Reset with arbitrary inputs: blank before any edge and while held.
    reset = 1'b1;
    turn_on = 8'hFF;
    for (int i = 0; i < 8; i++) in_v[i] = 4'(i + 3);
    #1;
    check_vec("reset_pre_edge", all_blank);
    @(posedge clock);
    #1;
    check_vec("reset_held", all_blank);
    @(negedge clock);
    reset = 1'b0;

    // Full table: every digit shows k.
    for (int k = 0; k < 16; k++) begin
      drive({8{4'(k)}}, 8'hFF);
      step($sformatf("table_%h", k));
    end

    // Digit mapping.
    drive(32'h1234_5678, 8'hFF);
    step("digit_map");

    // Blanking mask.
    drive(32'h0000_0000, 8'hA5);
    step("blank_A5");

    // Unknown nibble on a disabled digit must blank.
    drive({16'h9999, 4'bxxxx, 12'h999}, 8'hF7);
    step("x_disabled");

    // Latency: in0 changes between edges, output holds until the next edge.
    drive(32'h0000_0000, 8'hFF);
    step("lat_setup");
    drive(32'h0000_000F, 8'hFF);
    #2;
    check_one("lat_hold", 0, 7'h40);
    step("lat_update");

    // Async reset mid-run.
    drive(32'hFEDC_BA98, 8'hFF);
    step("pre_reset");
    #3;
    reset = 1'b1;
    #1;
    check_vec("async_reset", all_blank);
    @(posedge clock);
    #1;
    check_vec("async_reset_held", all_blank);
    @(negedge clock);
    reset = 1'b0;
    drive(32'h3C5A_0F69, 8'h7E);
    step("post_reset");

    if (sb.size() != 0) begin
      errors++;
      $error("FAIL scoreboard_drain: observed %0d leftover entries expected 0", sb.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
